// File: rtl/fde_pkg.sv
// Shared types and constants for the miniCPU fetch/decode/execute sequencer.
// Holds the state encoding, the instruction field layout and the NOP decode rule.
package fde_pkg;

  localparam int INSTR_W  = 16;
  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 12;
  localparam int SRC1_MSB = 11;
  localparam int SRC1_LSB = 8;
  localparam int SRC2_MSB = 7;
  localparam int SRC2_LSB = 4;
  localparam int DST_MSB  = 3;
  localparam int DST_LSB  = 0;

  localparam logic [3:0] DEFAULT_HALT_OPCODE = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXECUTE,
    WRITEBACK,
    HALT,
    PAUSE
  } state_t;

  // Opcodes with the top bit set are NOPs, except the one reserved for HALT.
  function automatic logic is_nop_op(input logic [3:0] op, input logic [3:0] halt_op);
    return op[3] && (op != halt_op);
  endfunction

endpackage

// File: rtl/fde_pc_counter.sv
// Program counter: W-bit up-counter with synchronous clear and increment enable.
// Clear has priority over increment; wraps silently at 2^W.
module fde_pc_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/fde_sequencer.sv
// miniCPU fetch/decode/execute sequencer: req/ack instruction fetch, field split, write strobe.
// Optional single-step mode (pause after each instruction) is enabled by FDE_SINGLE_STEP_EN.
module fde_sequencer
  import fde_pkg::*;
#(
  parameter int         PC_W        = 8,
  parameter logic [3:0] HALT_OPCODE = DEFAULT_HALT_OPCODE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
`ifdef FDE_SINGLE_STEP_EN
  input  logic               step,
`endif
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [3:0]         opcode,
  output logic [3:0]         srcadd_1,
  output logic [3:0]         srcadd_2,
  output logic [3:0]         dstadd,
  output logic               write_en,
  output logic               busy,
  output logic               halted,
  output logic [7:0]         retire_cnt
);

`ifdef FDE_SINGLE_STEP_EN
  localparam state_t RESUME = PAUSE;
`else
  localparam state_t RESUME = FETCH;
`endif

  state_t             state, state_nxt;
  logic [INSTR_W-1:0] ir;
  logic [7:0]         retire_q;
  logic               pc_clr, pc_inc, ir_load, retire_inc;
  logic [3:0]         ir_op;

  assign ir_op = ir[OP_MSB:OP_LSB];

  fde_pc_counter #(.W(PC_W)) u_pc (
    .clk   (clk),
    .reset (reset),
    .clr   (pc_clr),
    .inc   (pc_inc),
    .cnt   (imem_addr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ir       <= '0;
      retire_q <= '0;
    end else begin
      state <= state_nxt;
      if (ir_load) ir <= imem_data;
      if (pc_clr) retire_q <= '0;
      else if (retire_inc) retire_q <= retire_q + 8'd1;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_clr     = 1'b0;
    pc_inc     = 1'b0;
    ir_load    = 1'b0;
    retire_inc = 1'b0;
    case (state)
      IDLE, HALT: begin
        if (start) begin
          state_nxt = FETCH;
          pc_clr    = 1'b1;
        end
      end
      FETCH: begin
        // Address stays on pc until the ack; pc advances in the same edge that loads IR.
        if (imem_ack) begin
          state_nxt = DECODE;
          ir_load   = 1'b1;
          pc_inc    = 1'b1;
        end
      end
      DECODE: begin
        if (ir_op == HALT_OPCODE) state_nxt = HALT;
        else if (is_nop_op(ir_op, HALT_OPCODE)) state_nxt = RESUME;
        else state_nxt = EXECUTE;
      end
      EXECUTE: state_nxt = WRITEBACK;
      WRITEBACK: begin
        retire_inc = 1'b1;
        state_nxt  = RESUME;
      end
`ifdef FDE_SINGLE_STEP_EN
      PAUSE: begin
        if (step) state_nxt = FETCH;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  assign imem_req   = (state == FETCH);
  assign write_en   = (state == WRITEBACK);
  assign halted     = (state == HALT);
  assign busy       = (state == FETCH) || (state == DECODE) || (state == EXECUTE) ||
                      (state == WRITEBACK) || (state == PAUSE);
  assign opcode     = ir[OP_MSB:OP_LSB];
  assign srcadd_1   = ir[SRC1_MSB:SRC1_LSB];
  assign srcadd_2   = ir[SRC2_MSB:SRC2_LSB];
  assign dstadd     = ir[DST_MSB:DST_LSB];
  assign retire_cnt = retire_q;

endmodule
